// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// lane count and legality/alignment helpers.
package lsu_pkg;

    localparam int NUM_LANES = 4;
    localparam int DATA_W    = NUM_LANES * 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } lsu_state_e;

    // Unsigned variants exist only for loads; stores accept B/H/W.
    function automatic logic f3Legal(input logic isStore, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!isStore) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    function automatic logic f3Misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_H, F3_HU: bad = off[0];
            F3_W:        bad = (off != 2'b00);
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store strobe/replication and load
// shift/extension. Halfwords use ea[1] only, words ignore ea[1:0].
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]        st_funct3_i,
    input  logic [1:0]        st_off_i,
    input  logic [DATA_W-1:0] st_data_i,
    output logic [3:0]        st_wstrb_o,
    output logic [DATA_W-1:0] st_wdata_o,
    input  logic [2:0]        ld_funct3_i,
    input  logic [1:0]        ld_off_i,
    input  logic [DATA_W-1:0] ld_rdata_i,
    output logic [DATA_W-1:0] ld_data_o
);

    logic [4:0]        ldShamt;
    logic [DATA_W-1:0] ldShifted;

    always_comb begin
        st_wstrb_o = 4'b1111;
        st_wdata_o = st_data_i;
        case (st_funct3_i)
            F3_B: begin
                st_wstrb_o = 4'b0001 << st_off_i;
                st_wdata_o = {4{st_data_i[7:0]}};
            end
            F3_H: begin
                st_wstrb_o = st_off_i[1] ? 4'b1100 : 4'b0011;
                st_wdata_o = {2{st_data_i[15:0]}};
            end
            default: begin
                st_wstrb_o = 4'b1111;
                st_wdata_o = st_data_i;
            end
        endcase
    end

    always_comb begin
        ldShamt = 5'd0;
        case (ld_funct3_i)
            F3_B, F3_BU: ldShamt = {ld_off_i, 3'b000};
            F3_H, F3_HU: ldShamt = {ld_off_i[1], 4'b0000};
            default:     ldShamt = 5'd0;
        endcase
    end

    assign ldShifted = ld_rdata_i >> ldShamt;

    always_comb begin
        ld_data_o = ldShifted;
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{ldShifted[7]}}, ldShifted[7:0]};
            F3_BU:   ld_data_o = {24'd0, ldShifted[7:0]};
            F3_H:    ld_data_o = {{16{ldShifted[15]}}, ldShifted[15:0]};
            F3_HU:   ld_data_o = {16'd0, ldShifted[15:0]};
            default: ld_data_o = ldShifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit with req/ack memory handshake and core stall.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned halfword/word accesses into errors.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             op_valid_i,
    input  logic             op_store_i,
    input  logic [2:0]       funct3_i,
    input  logic [Width-1:0] base_i,
    input  logic [Width-1:0] offset_i,
    input  logic [Width-1:0] store_data_i,
    input  logic [4:0]       rd_i,
    output logic             stall_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [Width-1:0] mem_addr_o,
    output logic [Width-1:0] mem_wdata_o,
    output logic [3:0]       mem_wstrb_o,
    input  logic             mem_ack_i,
    input  logic [Width-1:0] mem_rdata_i,
    output logic             wb_en_o,
    output logic [4:0]       wb_rd_o,
    output logic [Width-1:0] wb_data_o,
    output logic             lsu_err_o
);

    lsu_state_e       state_q;
    logic [2:0]       funct3_q;
    logic [1:0]       eaLo_q;
    logic             isStore_q;
    logic [Width-1:0] ea;
    logic             opTrap;
    logic             opOk;
    logic [3:0]       stWstrb;
    logic [Width-1:0] stWdata;
    logic [Width-1:0] ldData;

    assign ea = base_i + offset_i;

`ifdef LSU_MISALIGN_TRAP_EN
    assign opTrap = f3Misaligned(funct3_i, ea[1:0]);
`else
    assign opTrap = 1'b0;
`endif

    assign opOk    = f3Legal(op_store_i, funct3_i) && !opTrap;
    assign stall_o = op_valid_i && (state_q != DONE);

    // Store lanes come from live operands; load lanes from the captured op.
    lsu_align u_align (
        .st_funct3_i (funct3_i),
        .st_off_i    (ea[1:0]),
        .st_data_i   (store_data_i),
        .st_wstrb_o  (stWstrb),
        .st_wdata_o  (stWdata),
        .ld_funct3_i (funct3_q),
        .ld_off_i    (eaLo_q),
        .ld_rdata_i  (mem_rdata_i),
        .ld_data_o   (ldData)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            funct3_q    <= 3'b000;
            eaLo_q      <= 2'b00;
            isStore_q   <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= 4'b0000;
            wb_en_o     <= 1'b0;
            wb_rd_o     <= 5'd0;
            wb_data_o   <= '0;
            lsu_err_o   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    wb_en_o   <= 1'b0;
                    lsu_err_o <= 1'b0;
                    if (op_valid_i) begin
                        funct3_q  <= funct3_i;
                        eaLo_q    <= ea[1:0];
                        isStore_q <= op_store_i;
                        wb_rd_o   <= rd_i;
                        if (opOk) begin
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= op_store_i;
                            mem_addr_o  <= {ea[Width-1:2], 2'b00};
                            mem_wdata_o <= stWdata;
                            mem_wstrb_o <= op_store_i ? stWstrb : 4'b0000;
                            state_q     <= REQ;
                        end else begin
                            lsu_err_o <= 1'b1;
                            state_q   <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        if (!isStore_q) begin
                            wb_data_o <= ldData;
                            wb_en_o   <= (wb_rd_o != 5'd0);
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    wb_en_o   <= 1'b0;
                    lsu_err_o <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized bench for load_store_unit against a byte-lane
// reference model; honours LSU_MISALIGN_TRAP_EN when defined.
module tb_load_store_unit;

    logic        clk;
    logic        rstN;
    logic        opValid;
    logic        opStore;
    logic [2:0]  funct3;
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] storeData;
    logic [4:0]  rd;
    logic        stall;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memWstrb;
    logic        memAck;
    logic [31:0] memRdata;
    logic        wbEn;
    logic [4:0]  wbRd;
    logic [31:0] wbData;
    logic        lsuErr;

    int checkCount = 0;
    int passCount  = 0;

    logic [31:0] lastAddr;
    logic [31:0] lastWdata;
    logic [31:0] lastWbData;
    logic [3:0]  lastWstrb;
    logic        lastWbEn;
    logic        lastErr;
    logic        lastReqSeen;
    int          lastStallCycles;
    int          lastDoneCycle;

    load_store_unit dut (
        .clk_i        (clk),
        .rst_n_i      (rstN),
        .op_valid_i   (opValid),
        .op_store_i   (opStore),
        .funct3_i     (funct3),
        .base_i       (base),
        .offset_i     (offset),
        .store_data_i (storeData),
        .rd_i         (rd),
        .stall_o      (stall),
        .mem_req_o    (memReq),
        .mem_we_o     (memWe),
        .mem_addr_o   (memAddr),
        .mem_wdata_o  (memWdata),
        .mem_wstrb_o  (memWstrb),
        .mem_ack_i    (memAck),
        .mem_rdata_i  (memRdata),
        .wb_en_o      (wbEn),
        .wb_rd_o      (wbRd),
        .wb_data_o    (wbData),
        .lsu_err_o    (lsuErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    function automatic logic modelLegal(input logic isStore, input logic [2:0] f3, input logic [31:0] ea);
        logic ok;
        int   n;
        ok = isStore ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        n  = 1 << f3[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        if (ok && n > 1 && (ea % n) != 0) ok = 1'b0;
`else
        if (ea == 32'hFFFF_FFFF) ok = ok && (n > 0);
`endif
        return ok;
    endfunction

    function automatic int modelBytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    // Lowest byte lane touched: bytes anywhere, halves in the low/high half, words at lane 0.
    function automatic int modelLane(input logic [2:0] f3, input logic [31:0] ea);
        int n;
        n = modelBytes(f3);
        if (n == 1) return int'(ea % 4);
        if (n == 2) return int'(ea % 4) / 2 * 2;
        return 0;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] ea, input logic [31:0] rdata);
        logic [31:0] v;
        int          n;
        n = modelBytes(f3);
        v = rdata >> (8 * modelLane(f3, ea));
        if (n == 1) begin
            v = v % 256;
            if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (n == 2) begin
            v = v % 65536;
            if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] modelStrobe(input logic [2:0] f3, input logic [31:0] ea);
        int m;
        m = ((1 << modelBytes(f3)) - 1) << modelLane(f3, ea);
        return m[3:0];
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] sd);
        int n;
        n = modelBytes(f3);
        if (n == 1) return (sd % 256) * 32'h0101_0101;
        if (n == 2) return (sd % 65536) * 32'h0001_0001;
        return sd;
    endfunction

    // Runs one instruction from the IDLE capture cycle through its return to IDLE.
    task automatic applyStimulus(input logic isStore, input logic [2:0] f3, input logic [31:0] b,
                                 input logic [31:0] off, input logic [31:0] sd, input logic [4:0] r,
                                 input int delay, input logic [31:0] rdata);
        logic [31:0] ea;
        logic        ok;
        int          cyc;
        ea  = b + off;
        ok  = modelLegal(isStore, f3, ea);
        cyc = 0;
        lastStallCycles = 0;
        lastReqSeen     = 1'b0;
        opValid = 1'b1; opStore = isStore; funct3 = f3;
        base = b; offset = off; storeData = sd; rd = r;
        #1;
        checkOutput("stall capture", {31'd0, stall}, 32'd1);
        lastStallCycles += int'(stall);
        @(posedge clk); @(negedge clk); cyc++;
        if (!ok) begin
            checkOutput("err pulse", {31'd0, lsuErr}, 32'd1);
            checkOutput("err no req", {31'd0, memReq}, 32'd0);
            checkOutput("err no wb", {31'd0, wbEn}, 32'd0);
            checkOutput("err stall", {31'd0, stall}, 32'd0);
            lastErr = lsuErr; lastWbEn = wbEn; lastDoneCycle = cyc;
        end else begin
            checkOutput("req", {31'd0, memReq}, 32'd1);
            checkOutput("addr", memAddr, ea & 32'hFFFF_FFFC);
            checkOutput("we", {31'd0, memWe}, {31'd0, isStore});
            if (isStore) begin
                checkOutput("wstrb", {28'd0, memWstrb}, {28'd0, modelStrobe(f3, ea)});
                checkOutput("wdata", memWdata, modelWdata(f3, sd));
            end
            lastAddr = memAddr; lastWstrb = memWstrb; lastWdata = memWdata;
            lastReqSeen = memReq;
            for (int i = 0; i < delay; i++) begin
                lastStallCycles += int'(stall);
                memRdata = $urandom;
                @(posedge clk); @(negedge clk); cyc++;
                checkOutput("req held", {31'd0, memReq}, 32'd1);
                checkOutput("addr held", memAddr, ea & 32'hFFFF_FFFC);
                if (isStore) checkOutput("wdata held", memWdata, modelWdata(f3, sd));
            end
            lastStallCycles += int'(stall);
            memAck = 1'b1; memRdata = rdata;
            @(posedge clk); @(negedge clk); cyc++;
            memAck = 1'b0; memRdata = $urandom;
            lastDoneCycle = cyc;
            checkOutput("done stall", {31'd0, stall}, 32'd0);
            checkOutput("done req", {31'd0, memReq}, 32'd0);
            checkOutput("done err", {31'd0, lsuErr}, 32'd0);
            checkOutput("wb_en", {31'd0, wbEn}, {31'd0, (!isStore && r != 5'd0)});
            if (!isStore && r != 5'd0) begin
                checkOutput("wb_rd", {27'd0, wbRd}, {27'd0, r});
                checkOutput("wb_data", wbData, modelLoad(f3, ea, rdata));
            end
            lastErr = lsuErr; lastWbEn = wbEn; lastWbData = wbData;
        end
        opValid = 1'b0;
        @(posedge clk); @(negedge clk);
        checkOutput("idle wb_en", {31'd0, wbEn}, 32'd0);
        checkOutput("idle err", {31'd0, lsuErr}, 32'd0);
        checkOutput("idle req", {31'd0, memReq}, 32'd0);
    endtask

    initial begin
        rstN = 1'b0; opValid = 1'b0; opStore = 1'b0; funct3 = 3'd0;
        base = '0; offset = '0; storeData = '0; rd = 5'd0;
        memAck = 1'b0; memRdata = '0;
        lastAddr = '0; lastWdata = '0; lastWbData = '0; lastWstrb = '0;
        lastWbEn = 1'b0; lastErr = 1'b0; lastReqSeen = 1'b0;
        lastStallCycles = 0; lastDoneCycle = 0;
        repeat (3) @(negedge clk);
        checkOutput("rst stall", {31'd0, stall}, 32'd0);
        checkOutput("rst req", {31'd0, memReq}, 32'd0);
        checkOutput("rst we", {31'd0, memWe}, 32'd0);
        checkOutput("rst addr", memAddr, 32'd0);
        checkOutput("rst wdata", memWdata, 32'd0);
        checkOutput("rst wstrb", {28'd0, memWstrb}, 32'd0);
        checkOutput("rst wb_en", {31'd0, wbEn}, 32'd0);
        checkOutput("rst wb_rd", {27'd0, wbRd}, 32'd0);
        checkOutput("rst wb_data", wbData, 32'd0);
        checkOutput("rst err", {31'd0, lsuErr}, 32'd0);
        rstN = 1'b1;
        @(negedge clk);

        applyStimulus(1'b0, 3'b010, 32'h100, 32'd4, 32'd0, 5'd5, 0, 32'hDEAD_BEEF);
        checkOutput("lw addr", lastAddr, 32'h104);
        checkOutput("lw wb_data", lastWbData, 32'hDEAD_BEEF);
        checkOutput("lw latency", lastDoneCycle, 32'd2);

        applyStimulus(1'b0, 3'b000, 32'h200, 32'd3, 32'd0, 5'd7, 0, 32'h80FF_1234);
        checkOutput("lb sext", lastWbData, 32'hFFFF_FF80);
        applyStimulus(1'b0, 3'b100, 32'h200, 32'd3, 32'd0, 5'd7, 0, 32'h80FF_1234);
        checkOutput("lbu zext", lastWbData, 32'h0000_0080);

        applyStimulus(1'b1, 3'b001, 32'h300, 32'd2, 32'h0000_ABCD, 5'd9, 0, 32'd0);
        checkOutput("sh wstrb", {28'd0, lastWstrb}, 32'hC);
        checkOutput("sh wdata", lastWdata, 32'hABCD_ABCD);
        checkOutput("sh addr", lastAddr, 32'h300);
        checkOutput("sh wb_en", {31'd0, lastWbEn}, 32'd0);

        applyStimulus(1'b0, 3'b010, 32'h400, 32'h10, 32'd0, 5'd3, 4, 32'h1234_5678);
        checkOutput("delay stall cycles", lastStallCycles, 32'd6);
        checkOutput("delay done cycle", lastDoneCycle, 32'd6);

        applyStimulus(1'b0, 3'b010, 32'h100, 32'd1, 32'd0, 5'd4, 0, 32'hCAFE_F00D);
`ifdef LSU_MISALIGN_TRAP_EN
        checkOutput("mis trap err", {31'd0, lastErr}, 32'd1);
        checkOutput("mis trap no req", {31'd0, lastReqSeen}, 32'd0);
`else
        checkOutput("mis addr", lastAddr, 32'h100);
        checkOutput("mis wb_data", lastWbData, 32'hCAFE_F00D);
`endif

        applyStimulus(1'b0, 3'b010, 32'h500, 32'd0, 32'd0, 5'd0, 1, 32'hFFFF_FFFF);
        checkOutput("rd0 wb_en", {31'd0, lastWbEn}, 32'd0);

        applyStimulus(1'b1, 3'b011, 32'h600, 32'd0, 32'h55, 5'd1, 0, 32'd0);
        checkOutput("illegal err", {31'd0, lastErr}, 32'd1);
        checkOutput("illegal latency", lastDoneCycle, 32'd1);

        // Reset in the middle of an outstanding request.
        opValid = 1'b1; opStore = 1'b0; funct3 = 3'b010;
        base = 32'h700; offset = 32'd0; rd = 5'd6;
        @(posedge clk); @(negedge clk);
        checkOutput("pre-rst req", {31'd0, memReq}, 32'd1);
        rstN = 1'b0;
        #1;
        checkOutput("rst drops req", {31'd0, memReq}, 32'd0);
        checkOutput("rst addr clr", memAddr, 32'd0);
        opValid = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        memAck = 1'b1; memRdata = 32'hAAAA_5555;
        @(posedge clk); @(negedge clk);
        memAck = 1'b0;
        checkOutput("stray ack req", {31'd0, memReq}, 32'd0);
        checkOutput("stray ack wb", {31'd0, wbEn}, 32'd0);
        checkOutput("stray ack err", {31'd0, lsuErr}, 32'd0);
        applyStimulus(1'b0, 3'b001, 32'h800, 32'd2, 32'd0, 5'd8, 0, 32'h8001_7FFF);
        checkOutput("post-rst lh", lastWbData, 32'hFFFF_8001);

        for (int n = 0; n < 60; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                          $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit for the single-cycle RISC-V core, sitting between the register file and the data memory. It consumes the register file read data (base address on RD1, store data on RD2) and drives the register file write port (RegWrite/W1/WD1) for loads. It stalls the core while a memory transaction is outstanding, using a req/ack handshake. It also handles byte/halfword lane placement, sign/zero extension, and alignment checking.

## Interface
- Width, 32, datapath width; only 32 is supported (4 byte lanes).
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  current instruction is a load/store; held with operands stable while stall=1.
- op_store  in  1  1=store, 0=load.
- funct3  in  3  RISC-V funct3 (size/sign).
- base  in  Width  RD1 from register file.
- offset  in  Width  sign-extended immediate.
- store_data  in  Width  RD2 from register file.
- rd  in  5  load destination register.
- stall  out  1  freeze PC/core this cycle.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  write enable.
- mem_addr  out  Width  word-aligned address (bits [1:0]=0).
- mem_wdata  out  Width  lane-replicated store data.
- mem_wstrb  out  4  byte strobes.
- mem_ack  in  1  completes the request in the cycle it is high with mem_req.
- mem_rdata  in  Width  read data, valid with mem_ack.
- wb_en  out  1  to RegWrite.
- wb_rd  out  5  to W1.
- wb_data  out  Width  to WD1.
- lsu_err  out  1  one-cycle pulse: misaligned or illegal funct3.

## Operation
- States: IDLE, REQ, DONE.
- IDLE:
  - On op_valid: capture ea=base+offset (modulo 2^32), op_store, funct3, rd, and store_data.
  - Legal, aligned op → REQ. Illegal or trapped op → DONE with error.
- REQ: mem_req=1 with registered address/strobes/data. On mem_ack → DONE. Loads capture the extended rdata into wb_data.
- DONE: single cycle, then unconditional → IDLE. The core advances at this edge, so op_valid still high in DONE never retriggers.
- stall = op_valid & (state!=DONE). It is combinational, so stall is already high in the IDLE capture cycle.
- Legal loads (funct3): LB 000, LH 001, LW 010, LBU 100, LHU 101. Legal stores: SB 000, SH 001, SW 010.
- Any other funct3 → no memory access, no writeback, lsu_err in DONE.
- Store lanes:
  - SB: wstrb = 1<<ea[1:0], byte replicated ×4.
  - SH: wstrb = ea[1] ? 1100 : 0011, halfword replicated ×2.
  - SW: wstrb = 1111.
- Load extract: shift rdata right by 8*ea[1:0], then take byte/half/word. LB/LH sign-extend; LBU/LHU zero-extend.
- wb_en=1 only in DONE, only for error-free loads with rd≠0. wb_rd and wb_data are valid only then.
- Stores never assert wb_en.

## Timing
- Reset (async, immediate): state=IDLE; mem_req, mem_we, wb_en, lsu_err=0; mem_addr, mem_wdata, wb_data=0; mem_wstrb=0; wb_rd=0.
- Minimum latency is 3 cycles: capture (IDLE), REQ with ack, DONE. Each extra cycle without mem_ack adds one cycle.
- All memory-side outputs and wb_* are registered. Only stall is combinational.
- mem_req, mem_addr, mem_we, mem_wstrb and mem_wdata stay stable from REQ entry until ack.
- mem_ack seen outside REQ is ignored.
- Reset during REQ drops mem_req immediately and abandons the transaction. The memory must tolerate this.
- Error path takes 2 cycles: IDLE → DONE with lsu_err=1, and mem_req is never asserted.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with ea[0]=1, or LW/SW with ea[1:0]≠0, is treated as an error. There is no access, no writeback, and lsu_err pulses in DONE.
- LSU_MISALIGN_TRAP_EN undefined: misaligned accesses proceed. Halfword uses ea[1] only; word ignores ea[1:0]. lsu_err then reports illegal funct3 only.

## Structure
- lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum (IDLE, REQ, DONE).
  - Byte-lane count localparam.
- Sub-module lsu_align: purely combinational.
  - Store side: (funct3, ea[1:0], store_data) → (wstrb, wdata).
  - Load side: (funct3, ea[1:0], rdata) → extended load data.
- The FSM and registers stay in load_store_unit.

## Test plan
- LW base=0x100, offset=4, rd=5, ack on first REQ cycle, rdata=0xDEADBEEF → mem_addr=0x104 in cycle 1; wb_en=1, wb_rd=5, wb_data=0xDEADBEEF in cycle 2; stall low in cycle 2.
- LB ea=0x203, rdata=0x80FF_1234 → wb_data=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH ea=0x302, store_data=0x0000ABCD → mem_we=1, wstrb=1100, mem_wdata=0xABCDABCD, mem_addr=0x300; wb_en stays 0.
- mem_ack delayed 4 cycles → mem_req and address stable throughout; stall high for 6 cycles total (capture + 4 wait + ack cycle); DONE in cycle 6.
- LW ea=0x101 with LSU_MISALIGN_TRAP_EN → no mem_req; lsu_err=1 in cycle 1; wb_en=0. Without the macro → mem_addr=0x100, normal writeback. Load with rd=0 → wb_en stays 0.
- rst_n low during REQ → mem_req=0 immediately; state IDLE; a later mem_ack is ignored. A new op after reset completes normally.
